// File: rtl/sc_node_egress_fifo.sv
// SC-channel egress buffer: DEPTH-entry first-word-fall-through FIFO between an SC node master side and the exit stage.
// Optional statistics outputs (beat_count, max_level) are compiled in when SC_NODE_FIFO_STATS_EN is defined.
module sc_node_egress_fifo #(
   parameter int PAYLD_W = 174,
   parameter int INFO_W  = 1,
   parameter int DEPTH   = 4
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       s_sc_req,
   input  logic                       s_sc_send,
   output logic                       s_sc_recv,
   input  logic [INFO_W-1:0]          s_sc_info,
   input  logic [PAYLD_W-1:0]         s_sc_payld,
   output logic                       m_sc_req,
   output logic                       m_sc_send,
   input  logic                       m_sc_recv,
   output logic [INFO_W-1:0]          m_sc_info,
   output logic [PAYLD_W-1:0]         m_sc_payld,
`ifdef SC_NODE_FIFO_STATS_EN
   output logic [31:0]                beat_count,
   output logic [$clog2(DEPTH):0]     max_level,
`endif
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = INFO_W + PAYLD_W;

   logic [EW-1:0] storage [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [LW-1:0] level_reg;
   logic [LW-1:0] level_next;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   // Upstream recv looks only at the level register, never at m_sc_recv.
   assign s_sc_recv = (level_reg != LW'(DEPTH));
   assign m_sc_send = (level_reg != '0);
   assign m_sc_req  = (level_reg != '0) | s_sc_req;
   assign push      = s_sc_send & s_sc_recv;
   assign pop       = m_sc_send & m_sc_recv;
   assign level     = level_reg;

   assign head       = storage[rd_ptr_reg];
   assign m_sc_payld = head[PAYLD_W-1:0];
   assign m_sc_info  = head[EW-1:PAYLD_W];

   always_comb begin
      level_next = level_reg;
      if (push && !pop) begin
         level_next = level_reg + LW'(1);
      end else if (pop && !push) begin
         level_next = level_reg - LW'(1);
      end
   end

   // Storage is intentionally left unreset; empty slots are don't-care.
   always_ff @(posedge aclk) begin
      if (push) begin
         storage[wr_ptr_reg] <= {s_sc_info, s_sc_payld};
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         level_reg <= level_next;
      end
   end

`ifdef SC_NODE_FIFO_STATS_EN
   logic [31:0]   beat_count_reg;
   logic [LW-1:0] max_level_reg;

   assign beat_count = beat_count_reg;
   assign max_level  = max_level_reg;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         beat_count_reg <= '0;
         max_level_reg  <= '0;
      end else begin
         if (pop) begin
            beat_count_reg <= beat_count_reg + 32'd1;
         end
         if (level_next > max_level_reg) begin
            max_level_reg <= level_next;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sc_node_egress_fifo.sv
// Self-checking bench for sc_node_egress_fifo: directed steps plus random traffic against a queue-based model.
// Define SC_NODE_FIFO_STATS_EN to also exercise the statistics outputs.
module tb_sc_node_egress_fifo;

   localparam int PW    = 174;
   localparam int IW    = 1;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          aclk = 1'b0;
   logic          areset;
   logic          s_sc_req;
   logic          s_sc_send;
   logic          s_sc_recv;
   logic [IW-1:0] s_sc_info;
   logic [PW-1:0] s_sc_payld;
   logic          m_sc_req;
   logic          m_sc_send;
   logic          m_sc_recv;
   logic [IW-1:0] m_sc_info;
   logic [PW-1:0] m_sc_payld;
   logic [LW-1:0] level;
`ifdef SC_NODE_FIFO_STATS_EN
   logic [31:0]   beat_count;
   logic [LW-1:0] max_level;
`endif

   sc_node_egress_fifo #(.PAYLD_W(PW), .INFO_W(IW), .DEPTH(DEPTH)) dut (
      .aclk       (aclk),
      .areset     (areset),
      .s_sc_req   (s_sc_req),
      .s_sc_send  (s_sc_send),
      .s_sc_recv  (s_sc_recv),
      .s_sc_info  (s_sc_info),
      .s_sc_payld (s_sc_payld),
      .m_sc_req   (m_sc_req),
      .m_sc_send  (m_sc_send),
      .m_sc_recv  (m_sc_recv),
      .m_sc_info  (m_sc_info),
      .m_sc_payld (m_sc_payld),
`ifdef SC_NODE_FIFO_STATS_EN
      .beat_count (beat_count),
      .max_level  (max_level),
`endif
      .level      (level)
   );

   always #5 aclk = ~aclk;

   // Reference model: queue of {info,payld}, oldest first.
   logic [IW+PW-1:0] q[$];
   int unsigned      m_pops;
   int unsigned      m_max;
   int               n_vec = 0;
   int               n_bad = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] rand_payld();
      logic [PW-1:0] v;
      for (int i = 0; i < PW; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".s_sc_recv"}, 256'(s_sc_recv), 256'(q.size() != DEPTH));
      chk({tag, ".m_sc_send"}, 256'(m_sc_send), 256'(q.size() != 0));
      chk({tag, ".m_sc_req"},  256'(m_sc_req),  256'((q.size() != 0) || s_sc_req));
      chk({tag, ".level"},     256'(level),     256'(q.size()));
      if (q.size() != 0) begin
         chk({tag, ".m_sc_payld"}, 256'(m_sc_payld), 256'(q[0][PW-1:0]));
         chk({tag, ".m_sc_info"},  256'(m_sc_info),  256'(q[0][IW+PW-1:PW]));
      end
`ifdef SC_NODE_FIFO_STATS_EN
      chk({tag, ".beat_count"}, 256'(beat_count), 256'(m_pops));
      chk({tag, ".max_level"},  256'(max_level),  256'(m_max));
`endif
   endtask

   function automatic void model_reset();
      q.delete();
      m_pops = 0;
      m_max  = 0;
   endfunction

   // One clock cycle: drive at negedge, check just after, then apply the edge to the model.
   task automatic step(input string tag, input logic send, input logic recv, input logic req,
                       input logic [PW-1:0] p, input logic [IW-1:0] inf);
      bit do_push;
      bit do_pop;
      s_sc_send  = send;
      m_sc_recv  = recv;
      s_sc_req   = req;
      s_sc_payld = p;
      s_sc_info  = inf;
      #1;
      check_outputs(tag);
      do_push = send && (q.size() < DEPTH);
      do_pop  = recv && (q.size() > 0);
      @(posedge aclk);
      if (do_pop) begin
         void'(q.pop_front());
         m_pops++;
      end
      if (do_push) q.push_back({inf, p});
      if (q.size() > m_max) m_max = q.size();
      @(negedge aclk);
   endtask

   task automatic rstep(input string tag, input logic send, input logic recv);
      step(tag, send, recv, 1'($urandom_range(0, 1)), rand_payld(), IW'($urandom));
   endtask

   logic [PW-1:0] pv;

   initial begin
      areset     = 1'b1;
      s_sc_req   = 1'b0;
      s_sc_send  = 1'b0;
      m_sc_recv  = 1'b0;
      s_sc_payld = '0;
      s_sc_info  = '0;
      model_reset();
      #1;
      check_outputs("reset");
      @(negedge aclk);
      areset = 1'b0;

      // Idle, then same-cycle request passthrough.
      step("idle", 1'b0, 1'b0, 1'b0, '0, '0);
      step("req_pass", 1'b0, 1'b0, 1'b1, '0, '0);

      // Fill with 0x11..0x44, then a fifth beat that must be held.
      for (int i = 1; i <= 4; i++) begin
         pv = PW'(i * 'h11);
         step("fill", 1'b1, 1'b0, 1'b0, pv, 1'(i));
      end
      pv = PW'('h55);
      step("full_hold", 1'b1, 1'b0, 1'b0, pv, '0);
      step("full_hold2", 1'b1, 1'b0, 1'b0, pv, '0);

      // Full with continuous send and recv.
      for (int i = 0; i < 8; i++) begin
         pv = PW'('h55 + i * 'h11);
         step("full_stream", 1'b1, 1'b1, 1'b0, pv, 1'(i));
      end

      // Drain, bounded.
      for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) rstep("drain", 1'b0, 1'b1);
      chk("drain_empty", 256'(level), 256'(0));

      // Level held at 2 while pushing and popping across pointer wrap.
      rstep("lvl2_fill", 1'b1, 1'b0);
      rstep("lvl2_fill", 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) rstep("lvl2_wrap", 1'b1, 1'b1);
      chk("lvl2_level", 256'(level), 256'(2));

      // Asynchronous reset mid-stream at level 3.
      rstep("pre_rst", 1'b1, 1'b0);
      chk("pre_rst_level", 256'(level), 256'(3));
      #2;
      areset = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(posedge aclk);
      #1;
      check_outputs("rst_hold");
      @(negedge aclk);
      areset = 1'b0;
      pv = PW'('hABC);
      step("post_rst_push", 1'b1, 1'b0, 1'b0, pv, 1'b1);
      step("post_rst_first", 1'b0, 1'b1, 1'b0, '0, '0);
      step("post_rst_empty", 1'b0, 1'b0, 1'b0, '0, '0);

`ifdef SC_NODE_FIFO_STATS_EN
      // Six beats with peak occupancy 3.
      areset = 1'b1;
      #1;
      model_reset();
      @(negedge aclk);
      areset = 1'b0;
      for (int i = 0; i < 3; i++) rstep("st_fill", 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) rstep("st_both", 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) rstep("st_drain", 1'b0, 1'b1);
      chk("st_beat_count", 256'(beat_count), 256'(6));
      chk("st_max_level", 256'(max_level), 256'(3));
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         rstep("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < 200; i++) begin
         rstep("rand_bp", ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
